ysyx_25010008_lsu_axi: RTL and testbench

Parametrised load/store unit. It sits between the core's memory stage and an AXI4-Lite-style data port, and is the successor to the fixed 32-bit LSU. Additions over that LSU:
- configurable data width, with doubleword access when XLEN=64;
- a req/resp handshake that replaces the done pulse;
- concurrent AW/W issue;
- fault reporting (misaligned, bus error, timeout) instead of halting the simulation;
- an MMIO flag output instead of a DPI call.

---
 rtl/ysyx_25010008_lsu_axi.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ysyx_25010008_lsu_axi.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25010008_lsu_axi.sv
// Parametrised load/store unit between the memory stage and an AXI4-Lite-style data port.
// Reports misaligned, bus-error and timeout faults and flags accesses to the MMIO window.
module ysyx_25010008_lsu_axi #(
   parameter int          XLEN      = 32,
   parameter int          TIMEOUT   = 0,
   parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
   parameter logic [31:0] MMIO_MASK = 32'hFFFF_F000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wen,
   input  logic [1:0]          req_size,
   input  logic                req_sext,
   input  logic [31:0]         req_addr,
   input  logic [XLEN-1:0]     req_wdata,
   output logic                resp_valid,
   output logic [XLEN-1:0]     resp_rdata,
   output logic [1:0]          resp_fault,
   output logic                resp_mmio,
   output logic [31:0]         araddr,
   output logic [2:0]          arsize,
   output logic                arvalid,
   input  logic                arready,
   output logic                rready,
   input  logic [XLEN-1:0]     rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic [31:0]         awaddr,
   output logic [2:0]          awsize,
   output logic                awvalid,
   input  logic                awready,
   output logic [XLEN-1:0]     wdata,
   output logic [XLEN/8-1:0]   wstrb,
   output logic                wvalid,
   input  logic                wready,
   output logic                bready,
   input  logic [1:0]          bresp,
   input  logic                bvalid
);

   localparam int          STRB     = XLEN / 8;
   localparam int          OFF      = $clog2(XLEN / 8);
   localparam logic [31:0] TO_LIMIT = TIMEOUT;

   localparam logic [1:0] F_OK    = 2'd0;
   localparam logic [1:0] F_ALIGN = 2'd1;
   localparam logic [1:0] F_BUS   = 2'd2;
   localparam logic [1:0] F_TIME  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AR   = 3'd1,
      S_R    = 3'd2,
      S_AWW  = 3'd3,
      S_B    = 3'd4,
      S_RESP = 3'd5
   } state_t;

   state_t          state_r;
   logic [31:0]     addr_r;
   logic [1:0]      size_r;
   logic            sext_r;
   logic            mmio_r;
   logic            aw_done_r;
   logic            w_done_r;
   logic [31:0]     cnt_r;

   logic            misal_s;
   logic            mmio_s;
   logic [STRB-1:0] strb_base_s;
   logic [STRB-1:0] wstrb_next_s;
   logic [XLEN-1:0] wdata_next_s;
   logic [XLEN-1:0] sh_s;
   logic [XLEN-1:0] keep_s;
   logic            sign_s;
   logic [XLEN-1:0] load_data_s;
   logic            bus_state_s;
   logic            timeout_s;
   logic            aw_now_s;
   logic            w_now_s;

   assign araddr = addr_r;
   assign awaddr = addr_r;
   assign arsize = {1'b0, size_r};
   assign awsize = {1'b0, size_r};

   // Request decode: alignment, MMIO window and lane placement of store data.
   always_comb begin
      misal_s     = 1'b0;
      strb_base_s = {STRB{1'b1}};
      case (req_size)
         2'd0: begin
            misal_s     = 1'b0;
            strb_base_s = {STRB{1'b1}} >> (STRB - 1);
         end
         2'd1: begin
            misal_s     = req_addr[0];
            strb_base_s = {STRB{1'b1}} >> (STRB - 2);
         end
         2'd2: begin
            misal_s     = (req_addr[1:0] != 2'b00);
            strb_base_s = {STRB{1'b1}} >> (STRB - 4);
         end
         2'd3: begin
            misal_s     = (XLEN == 32) || (req_addr[2:0] != 3'b000);
            strb_base_s = {STRB{1'b1}};
         end
         default: begin
            misal_s     = 1'b1;
            strb_base_s = {STRB{1'b0}};
         end
      endcase
      mmio_s       = ((req_addr & MMIO_MASK) == MMIO_BASE);
      wstrb_next_s = strb_base_s << req_addr[OFF-1:0];
      wdata_next_s = req_wdata << {req_addr[OFF-1:0], 3'b000};
   end

   // Load data alignment: shift the addressed lane down, then truncate and extend.
   always_comb begin
      sh_s   = rdata >> {addr_r[OFF-1:0], 3'b000};
      keep_s = {XLEN{1'b1}};
      sign_s = 1'b0;
      case (size_r)
         2'd0: begin
            keep_s = {XLEN{1'b1}} >> (XLEN - 8);
            sign_s = sh_s[7];
         end
         2'd1: begin
            keep_s = {XLEN{1'b1}} >> (XLEN - 16);
            sign_s = sh_s[15];
         end
         2'd2: begin
            keep_s = {XLEN{1'b1}} >> (XLEN - 32);
            sign_s = sh_s[31];
         end
         2'd3: begin
            keep_s = {XLEN{1'b1}};
            sign_s = sh_s[XLEN-1];
         end
         default: begin
            keep_s = {XLEN{1'b0}};
            sign_s = 1'b0;
         end
      endcase
      if (sext_r && sign_s) begin
         load_data_s = (sh_s & keep_s) | ~keep_s;
      end else begin
         load_data_s = sh_s & keep_s;
      end
   end

   // Bus-wait watchdog and AW/W completion tracking.
   always_comb begin
      bus_state_s = (state_r == S_AR) || (state_r == S_R) ||
                    (state_r == S_AWW) || (state_r == S_B);
      if (TO_LIMIT != 32'd0) begin
         timeout_s = bus_state_s && ((cnt_r + 32'd1) == TO_LIMIT);
      end else begin
         timeout_s = 1'b0;
      end
      aw_now_s = aw_done_r || (awvalid && awready);
      w_now_s  = w_done_r || (wvalid && wready);
   end

   // Main FSM; every output is a register written here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= S_IDLE;
         req_ready  <= 1'b1;
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         bready     <= 1'b0;
         resp_valid <= 1'b0;
         resp_fault <= F_OK;
         resp_mmio  <= 1'b0;
         resp_rdata <= {XLEN{1'b0}};
         wdata      <= {XLEN{1'b0}};
         wstrb      <= {STRB{1'b0}};
         addr_r     <= 32'd0;
         size_r     <= 2'd0;
         sext_r     <= 1'b0;
         mmio_r     <= 1'b0;
         aw_done_r  <= 1'b0;
         w_done_r   <= 1'b0;
         cnt_r      <= 32'd0;
      end else if (timeout_s) begin
         // Abandon the transaction; a late response is simply never consumed.
         arvalid    <= 1'b0;
         rready     <= 1'b0;
         awvalid    <= 1'b0;
         wvalid     <= 1'b0;
         bready     <= 1'b0;
         state_r    <= S_RESP;
         resp_valid <= 1'b1;
         resp_fault <= F_TIME;
         resp_mmio  <= mmio_r;
         resp_rdata <= {XLEN{1'b0}};
      end else begin
         case (state_r)
            S_IDLE: begin
               if (req_valid) begin
                  addr_r    <= req_addr;
                  size_r    <= req_size;
                  sext_r    <= req_sext;
                  mmio_r    <= mmio_s;
                  cnt_r     <= 32'd0;
                  req_ready <= 1'b0;
                  wdata     <= wdata_next_s;
                  wstrb     <= wstrb_next_s;
                  if (misal_s) begin
                     state_r    <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= F_ALIGN;
                     resp_mmio  <= mmio_s;
                     resp_rdata <= {XLEN{1'b0}};
                  end else if (req_wen) begin
                     state_r   <= S_AWW;
                     awvalid   <= 1'b1;
                     wvalid    <= 1'b1;
                     aw_done_r <= 1'b0;
                     w_done_r  <= 1'b0;
                  end else begin
                     state_r <= S_AR;
                     arvalid <= 1'b1;
                  end
               end
            end
            S_AR: begin
               cnt_r <= cnt_r + 32'd1;
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state_r <= S_R;
               end
            end
            S_R: begin
               cnt_r <= cnt_r + 32'd1;
               if (rvalid) begin
                  rready     <= 1'b0;
                  state_r    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_mmio  <= mmio_r;
                  if (rresp != 2'b00) begin
                     resp_fault <= F_BUS;
                     resp_rdata <= {XLEN{1'b0}};
                  end else begin
                     resp_fault <= F_OK;
                     resp_rdata <= load_data_s;
                  end
               end
            end
            S_AWW: begin
               cnt_r <= cnt_r + 32'd1;
               if (aw_now_s && w_now_s) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b0;
                  bready  <= 1'b1;
                  state_r <= S_B;
               end else begin
                  awvalid   <= !aw_now_s;
                  wvalid    <= !w_now_s;
                  aw_done_r <= aw_now_s;
                  w_done_r  <= w_now_s;
               end
            end
            S_B: begin
               cnt_r <= cnt_r + 32'd1;
               if (bvalid) begin
                  bready     <= 1'b0;
                  state_r    <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_mmio  <= mmio_r;
                  resp_rdata <= {XLEN{1'b0}};
                  resp_fault <= (bresp != 2'b00) ? F_BUS : F_OK;
               end
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               resp_fault <= F_OK;
               resp_mmio  <= 1'b0;
               resp_rdata <= {XLEN{1'b0}};
               req_ready  <= 1'b1;
               state_r    <= S_IDLE;
            end
            default: begin
               state_r   <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25010008_lsu_axi.sv
// Directed bench: a 32-bit LSU (TIMEOUT=16) and a 64-bit LSU share stimulus, one selected at a time.
module tb_ysyx_25010008_lsu_axi;

   logic        clock;
   logic        reset;
   logic        a_req_valid;
   logic        b_req_valid;
   logic        req_wen;
   logic [1:0]  req_size;
   logic        req_sext;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        awready;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;

   logic        a_req_ready, a_resp_valid, a_resp_mmio, a_arvalid, a_rready;
   logic        a_awvalid, a_wvalid, a_bready;
   logic [31:0] a_resp_rdata, a_araddr, a_awaddr, a_wdata;
   logic [1:0]  a_resp_fault;
   logic [2:0]  a_arsize, a_awsize;
   logic [3:0]  a_wstrb;

   logic        b_req_ready, b_resp_valid, b_resp_mmio, b_arvalid, b_rready;
   logic        b_awvalid, b_wvalid, b_bready;
   logic [63:0] b_resp_rdata, b_wdata;
   logic [31:0] b_araddr, b_awaddr;
   logic [1:0]  b_resp_fault;
   logic [2:0]  b_arsize, b_awsize;
   logic [7:0]  b_wstrb;

   logic        sel;
   int          n_cmp;
   int          n_err;

   ysyx_25010008_lsu_axi #(.XLEN(32), .TIMEOUT(16)) dut_a (
      .clock(clock), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(req_wen),
      .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata[31:0]),
      .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_fault(a_resp_fault),
      .resp_mmio(a_resp_mmio),
      .araddr(a_araddr), .arsize(a_arsize), .arvalid(a_arvalid), .arready(arready),
      .rready(a_rready), .rdata(rdata[31:0]), .rresp(rresp), .rvalid(rvalid),
      .awaddr(a_awaddr), .awsize(a_awsize), .awvalid(a_awvalid), .awready(awready),
      .wdata(a_wdata), .wstrb(a_wstrb), .wvalid(a_wvalid), .wready(wready),
      .bready(a_bready), .bresp(bresp), .bvalid(bvalid)
   );

   ysyx_25010008_lsu_axi #(.XLEN(64), .TIMEOUT(0)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
      .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault),
      .resp_mmio(b_resp_mmio),
      .araddr(b_araddr), .arsize(b_arsize), .arvalid(b_arvalid), .arready(arready),
      .rready(b_rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
      .awaddr(b_awaddr), .awsize(b_awsize), .awvalid(b_awvalid), .awready(awready),
      .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(wready),
      .bready(b_bready), .bresp(bresp), .bvalid(bvalid)
   );

   // Outputs of whichever instance is currently under test.
   logic        m_req_ready, m_resp_valid, m_resp_mmio, m_arvalid, m_rready;
   logic        m_awvalid, m_wvalid, m_bready;
   logic [63:0] m_resp_rdata, m_wdata;
   logic [31:0] m_araddr, m_awaddr;
   logic [1:0]  m_resp_fault;
   logic [2:0]  m_arsize, m_awsize;
   logic [7:0]  m_wstrb;

   assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
   assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
   assign m_resp_mmio  = sel ? b_resp_mmio  : a_resp_mmio;
   assign m_arvalid    = sel ? b_arvalid    : a_arvalid;
   assign m_rready     = sel ? b_rready     : a_rready;
   assign m_awvalid    = sel ? b_awvalid    : a_awvalid;
   assign m_wvalid     = sel ? b_wvalid     : a_wvalid;
   assign m_bready     = sel ? b_bready     : a_bready;
   assign m_resp_rdata = sel ? b_resp_rdata : {32'd0, a_resp_rdata};
   assign m_wdata      = sel ? b_wdata      : {32'd0, a_wdata};
   assign m_araddr     = sel ? b_araddr     : a_araddr;
   assign m_awaddr     = sel ? b_awaddr     : a_awaddr;
   assign m_resp_fault = sel ? b_resp_fault : a_resp_fault;
   assign m_arsize     = sel ? b_arsize     : a_arsize;
   assign m_awsize     = sel ? b_awsize     : a_awsize;
   assign m_wstrb      = sel ? b_wstrb      : {4'd0, a_wstrb};

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request at a negedge; returns at the negedge of cycle 1.
   task automatic issue(input logic wen, input logic [1:0] size, input logic sext,
                        input logic [31:0] addr, input logic [63:0] wd);
      chk("req_ready_idle", {63'd0, m_req_ready}, 64'd1);
      req_wen   = wen;
      req_size  = size;
      req_sext  = sext;
      req_addr  = addr;
      req_wdata = wd;
      if (sel) b_req_valid = 1'b1;
      else     a_req_valid = 1'b1;
      @(negedge clock);
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic sext,
                          input logic [31:0] addr, input logic [63:0] rd, input logic [1:0] rr,
                          input logic [63:0] exp_rd, input logic [1:0] exp_f);
      arready = 1'b1;
      rvalid  = 1'b0;
      issue(1'b0, size, sext, addr, 64'd0);
      chk({tag, "/arvalid_c1"}, {63'd0, m_arvalid}, 64'd1);
      chk({tag, "/araddr"}, {32'd0, m_araddr}, {32'd0, addr});
      chk({tag, "/arsize"}, {61'd0, m_arsize}, {62'd0, size});
      chk({tag, "/req_ready_busy"}, {63'd0, m_req_ready}, 64'd0);
      @(negedge clock);
      chk({tag, "/rready_c2"}, {63'd0, m_rready}, 64'd1);
      chk({tag, "/arvalid_c2"}, {63'd0, m_arvalid}, 64'd0);
      rvalid = 1'b1;
      rdata  = rd;
      rresp  = rr;
      @(negedge clock);
      rvalid = 1'b0;
      rresp  = 2'b00;
      chk({tag, "/resp_valid_c3"}, {63'd0, m_resp_valid}, 64'd1);
      chk({tag, "/resp_rdata"}, m_resp_rdata, exp_rd);
      chk({tag, "/resp_fault"}, {62'd0, m_resp_fault}, {62'd0, exp_f});
      chk({tag, "/resp_mmio"}, {63'd0, m_resp_mmio}, 64'd0);
      @(negedge clock);
      chk({tag, "/resp_valid_c4"}, {63'd0, m_resp_valid}, 64'd0);
      chk({tag, "/req_ready_c4"}, {63'd0, m_req_ready}, 64'd1);
   endtask

   task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] addr,
                           input logic [63:0] wd, input logic [63:0] exp_wd, input logic [7:0] exp_st,
                           input logic [1:0] br, input logic [1:0] exp_f, input logic exp_mmio);
      awready = 1'b1;
      wready  = 1'b1;
      bvalid  = 1'b0;
      issue(1'b1, size, 1'b0, addr, wd);
      chk({tag, "/awvalid_c1"}, {63'd0, m_awvalid}, 64'd1);
      chk({tag, "/wvalid_c1"}, {63'd0, m_wvalid}, 64'd1);
      chk({tag, "/awaddr"}, {32'd0, m_awaddr}, {32'd0, addr});
      chk({tag, "/awsize"}, {61'd0, m_awsize}, {62'd0, size});
      chk({tag, "/wdata"}, m_wdata, exp_wd);
      chk({tag, "/wstrb"}, {56'd0, m_wstrb}, {56'd0, exp_st});
      @(negedge clock);
      chk({tag, "/bready_c2"}, {63'd0, m_bready}, 64'd1);
      chk({tag, "/awvalid_c2"}, {63'd0, m_awvalid}, 64'd0);
      bvalid = 1'b1;
      bresp  = br;
      @(negedge clock);
      bvalid = 1'b0;
      bresp  = 2'b00;
      chk({tag, "/resp_valid_c3"}, {63'd0, m_resp_valid}, 64'd1);
      chk({tag, "/resp_fault"}, {62'd0, m_resp_fault}, {62'd0, exp_f});
      chk({tag, "/resp_mmio"}, {63'd0, m_resp_mmio}, {63'd0, exp_mmio});
      chk({tag, "/resp_rdata"}, m_resp_rdata, 64'd0);
      @(negedge clock);
      chk({tag, "/resp_valid_c4"}, {63'd0, m_resp_valid}, 64'd0);
   endtask

   task automatic do_misal(input string tag, input logic [1:0] size, input logic [31:0] addr);
      arready = 1'b1;
      issue(1'b0, size, 1'b0, addr, 64'd0);
      chk({tag, "/resp_valid_c1"}, {63'd0, m_resp_valid}, 64'd1);
      chk({tag, "/resp_fault"}, {62'd0, m_resp_fault}, 64'd1);
      chk({tag, "/arvalid_c1"}, {63'd0, m_arvalid}, 64'd0);
      @(negedge clock);
      chk({tag, "/resp_valid_c2"}, {63'd0, m_resp_valid}, 64'd0);
      chk({tag, "/arvalid_c2"}, {63'd0, m_arvalid}, 64'd0);
      chk({tag, "/req_ready_c2"}, {63'd0, m_req_ready}, 64'd1);
   endtask

   initial begin
      int hi;
      logic seen;
      n_cmp = 0;
      n_err = 0;
      sel = 1'b0;
      reset = 1'b1;
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      req_wen = 1'b0; req_size = 2'd0; req_sext = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
      arready = 1'b0; rdata = 64'd0; rresp = 2'b00; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;

      @(negedge clock);
      chk("rst/req_ready", {63'd0, m_req_ready}, 64'd1);
      chk("rst/arvalid", {63'd0, m_arvalid}, 64'd0);
      chk("rst/awvalid", {63'd0, m_awvalid}, 64'd0);
      chk("rst/wvalid", {63'd0, m_wvalid}, 64'd0);
      chk("rst/bready", {63'd0, m_bready}, 64'd0);
      chk("rst/rready", {63'd0, m_rready}, 64'd0);
      chk("rst/resp_valid", {63'd0, m_resp_valid}, 64'd0);
      chk("rst/resp_rdata", m_resp_rdata, 64'd0);
      chk("rst/b_req_ready", {63'd0, b_req_ready}, 64'd1);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // 32-bit instance
      do_load("lb", 2'd0, 1'b1, 32'h8000_0003, 64'h0000_0000_80FF_1234, 2'b00, 64'hFFFF_FF80, 2'd0);
      do_load("lbu", 2'd0, 1'b0, 32'h8000_0003, 64'h0000_0000_80FF_1234, 2'b00, 64'h0000_0080, 2'd0);
      do_load("lh", 2'd1, 1'b1, 32'h8000_0002, 64'h0000_0000_80FF_1234, 2'b00, 64'hFFFF_80FF, 2'd0);
      do_load("lw_berr", 2'd2, 1'b0, 32'h8000_0004, 64'h0000_0000_1234_5678, 2'b10, 64'd0, 2'd2);
      do_misal("lw_misal", 2'd2, 32'h8000_0002);
      do_misal("ld_on32", 2'd3, 32'h8000_0000);
      do_store("sw_mmio", 2'd2, 32'h1000_0000, 64'h1234_5678, 64'h1234_5678, 8'h0F, 2'b00, 2'd0, 1'b1);
      do_store("sb_berr", 2'd0, 32'h8000_0001, 64'hAB, 64'hAB00, 8'h02, 2'b10, 2'd2, 1'b0);

      // sh with awready held low for three cycles
      awready = 1'b0;
      wready  = 1'b1;
      bvalid  = 1'b0;
      issue(1'b1, 2'd1, 1'b0, 32'h8000_0002, 64'h0000_ABCD);
      chk("sh/awvalid_c1", {63'd0, m_awvalid}, 64'd1);
      chk("sh/wvalid_c1", {63'd0, m_wvalid}, 64'd1);
      chk("sh/wdata", m_wdata, 64'hABCD_0000);
      chk("sh/wstrb", {56'd0, m_wstrb}, 64'hC);
      chk("sh/awsize", {61'd0, m_awsize}, 64'd1);
      @(negedge clock);
      chk("sh/wvalid_c2", {63'd0, m_wvalid}, 64'd0);
      chk("sh/awvalid_c2", {63'd0, m_awvalid}, 64'd1);
      @(negedge clock);
      chk("sh/awvalid_c3", {63'd0, m_awvalid}, 64'd1);
      chk("sh/bready_c3", {63'd0, m_bready}, 64'd0);
      @(negedge clock);
      chk("sh/awvalid_c4", {63'd0, m_awvalid}, 64'd1);
      awready = 1'b1;
      @(negedge clock);
      awready = 1'b0;
      chk("sh/awvalid_c5", {63'd0, m_awvalid}, 64'd0);
      chk("sh/bready_c5", {63'd0, m_bready}, 64'd1);
      bvalid = 1'b1;
      @(negedge clock);
      bvalid = 1'b0;
      chk("sh/resp_valid", {63'd0, m_resp_valid}, 64'd1);
      chk("sh/resp_fault", {62'd0, m_resp_fault}, 64'd0);
      chk("sh/bready_c6", {63'd0, m_bready}, 64'd0);
      @(negedge clock);
      chk("sh/resp_valid_c7", {63'd0, m_resp_valid}, 64'd0);

      // timeout with arready stuck low
      arready = 1'b0;
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, 64'd0);
      hi = 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (m_resp_valid) begin
            seen = 1'b1;
            chk("to/fault", {62'd0, m_resp_fault}, 64'd3);
            chk("to/arvalid_low", {63'd0, m_arvalid}, 64'd0);
            chk("to/arvalid_cycles", 64'(hi), 64'd16);
         end else begin
            if (m_arvalid) hi++;
            @(negedge clock);
         end
      end
      chk("to/resp_seen", {63'd0, seen}, 64'd1);
      @(negedge clock);
      chk("to/req_ready", {63'd0, m_req_ready}, 64'd1);
      arready = 1'b1;

      // reset while waiting in R
      rvalid = 1'b0;
      issue(1'b0, 2'd2, 1'b0, 32'h8000_0000, 64'd0);
      @(negedge clock);
      chk("rstR/rready_before", {63'd0, m_rready}, 64'd1);
      reset  = 1'b1;
      rvalid = 1'b1;
      rdata  = 64'h0000_0000_5555_AAAA;
      @(negedge clock);
      reset  = 1'b0;
      rvalid = 1'b0;
      chk("rstR/rready", {63'd0, m_rready}, 64'd0);
      chk("rstR/req_ready", {63'd0, m_req_ready}, 64'd1);
      chk("rstR/resp_valid", {63'd0, m_resp_valid}, 64'd0);
      @(negedge clock);
      chk("rstR/resp_valid_next", {63'd0, m_resp_valid}, 64'd0);
      do_load("after_rst", 2'd2, 1'b0, 32'h8000_0010, 64'h0000_0000_1357_9BDF, 2'b00, 64'h1357_9BDF, 2'd0);

      // 64-bit instance
      sel = 1'b1;
      do_load("ld", 2'd3, 1'b0, 32'h8000_0008, 64'hDEAD_BEEF_0123_4567, 2'b00, 64'hDEAD_BEEF_0123_4567, 2'd0);
      do_load("lw64", 2'd2, 1'b1, 32'h8000_0004, 64'h8000_0000_1234_5678, 2'b00, 64'hFFFF_FFFF_8000_0000, 2'd0);
      do_load("lwu64", 2'd2, 1'b0, 32'h8000_0004, 64'h8000_0000_1234_5678, 2'b00, 64'h0000_0000_8000_0000, 2'd0);
      do_store("sh64", 2'd1, 32'h8000_0006, 64'hBEEF, 64'hBEEF_0000_0000_0000, 8'hC0, 2'b00, 2'd0, 1'b0);
      do_misal("ld_misal", 2'd3, 32'h8000_0004);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
